ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit anode timing with guard blanking,
// frame-atomic display updates through a shadow register, and optional leading-zero blanking.
module ssd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [3:0]              hex_sel,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    load_ack
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CntLast = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxLast = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StBlank, StOn} state_e;
    localparam state_e StReset = (BLANK_CYC == 0) ? StOn : StBlank;

    logic [CW-1:0]                 div_cnt_q, div_cnt_d;
    logic [IW-1:0]                 idx_q, idx_d;
    state_e                        state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]    act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]         act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0][3:0]    shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0]         shd_dp_q, shd_dp_d;
    logic                          pending_q, pending_d;
    logic [3:0]                    hex_q, hex_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic                          dp_q, dp_d;
    logic                          ack_q, ack_d;

    logic boundary;
    logic suppress;
    logic zero_run;
    logic lit;

    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        state_d   = state_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        shd_val_d = shd_val_q;
        shd_dp_d  = shd_dp_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        boundary  = en && (div_cnt_q == CntLast) && (idx_q == IdxLast);

        if (en) begin
            if (div_cnt_q == CntLast) begin
                div_cnt_d = '0;
                idx_d     = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
            end else begin
                div_cnt_d = div_cnt_q + CW'(1);
            end
            if (div_cnt_d == '0 && BLANK_CYC != 0) begin
                state_d = StBlank;
            end else if (32'(div_cnt_d) == BLANK_CYC) begin
                state_d = StOn;
            end
        end

        // A load on the boundary edge wins over anything still waiting in the shadow.
        if (boundary) begin
            if (load) begin
                act_val_d = value_in;
                act_dp_d  = dp_in;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end else if (pending_q) begin
                act_val_d = shd_val_q;
                act_dp_d  = shd_dp_q;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end
        end else if (load) begin
            shd_val_d = value_in;
            shd_dp_d  = dp_in;
            pending_d = 1'b1;
        end

        // Walk down from the top digit; zero_run stays set while every nibble so far is zero.
        zero_run = 1'b1;
        suppress = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (act_val_d[k] == 4'h0);
            if (idx_d == IW'(k) && zero_run && !act_dp_d[k]) begin
                suppress = lz_en;
            end
        end

        lit  = en && (state_d == StOn) && !suppress;
        an_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lit && idx_d == IW'(k)) begin
                an_d[k] = 1'b0;
            end
        end
        hex_d = act_val_d[idx_d];
        dp_d  = !(en && (state_d == StOn) && act_dp_d[idx_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= StReset;
            act_val_q <= '0;
            act_dp_q  <= '0;
            shd_val_q <= '0;
            shd_dp_q  <= '0;
            pending_q <= 1'b0;
            hex_q     <= 4'h0;
            an_q      <= '1;
            dp_q      <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            shd_val_q <= shd_val_d;
            shd_dp_q  <= shd_dp_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
            ack_q     <= ack_d;
        end
    end

    assign hex_sel  = hex_q;
    assign an_n     = an_q;
    assign dp_n     = dp_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl (4 digits, 8 clocks per slot, 2 guard cycles):
// expected digit-light events and ack pulses are queued by the stimulus and popped by a monitor.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  hex_sel;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        load_ack;

    int errors = 0;
    int checks = 0;
    int ecnt = 0;

    typedef struct {
        int         at;
        logic [3:0] an;
        logic [3:0] hex;
        logic       dp;
    } dig_t;

    dig_t dq[$];
    int   aq[$];

    ssd_scan_ctrl #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .value_in(value_in),
        .dp_in   (dp_in),
        .lz_en   (lz_en),
        .hex_sel (hex_sel),
        .an_n    (an_n),
        .dp_n    (dp_n),
        .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge k leaves the scan in its k-th state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    function automatic void push_dig(int at, logic [3:0] an, logic [3:0] hex, logic dp);
        dig_t e;
        e.at = at; e.an = an; e.hex = hex; e.dp = dp;
        dq.push_back(e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto(int k);
        while (ecnt < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_at(int k, logic [15:0] v, logic [3:0] d);
        goto(k - 1);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        goto(k);
        load     = 1'b0;
    endtask

    // Monitor: a digit "presents" when its anode turns on after a dark period.
    initial begin
        logic [3:0] prev_an;
        dig_t       e;
        int         a;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_an = 4'hF;
            end else begin
                if (an_n != 4'hF && prev_an == 4'hF) begin
                    checks++;
                    if (dq.size() == 0) begin
                        errors++;
                        $display("FAIL digit_event: unexpected an_n=%b hex=%h dp_n=%b at edge %0d",
                                 an_n, hex_sel, dp_n, ecnt);
                    end else begin
                        e = dq.pop_front();
                        if (e.at != ecnt || e.an != an_n || e.hex != hex_sel || e.dp != dp_n) begin
                            errors++;
                            $display("FAIL digit_event: got edge %0d an_n=%b hex=%h dp_n=%b, expected edge %0d an_n=%b hex=%h dp_n=%b",
                                     ecnt, an_n, hex_sel, dp_n, e.at, e.an, e.hex, e.dp);
                        end
                    end
                end
                if (load_ack) begin
                    checks++;
                    if (aq.size() == 0) begin
                        errors++;
                        $display("FAIL load_ack: unexpected pulse at edge %0d, expected none", ecnt);
                    end else begin
                        a = aq.pop_front();
                        if (a != ecnt) begin
                            errors++;
                            $display("FAIL load_ack: got pulse at edge %0d expected edge %0d", ecnt, a);
                        end
                    end
                end
                prev_an = an_n;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_an_n", 32'(an_n), 32'hF);
        chk("reset_hex_sel", 32'(hex_sel), 32'h0);
        chk("reset_dp_n", 32'(dp_n), 32'h1);
        chk("reset_load_ack", 32'(load_ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Frame 0 shows zeros, 0x1234 commits at edge 32, frame 1 scans 4,3,2,1.
        push_dig(2, 4'hE, 4'h0, 1'b1);  push_dig(10, 4'hD, 4'h0, 1'b1);
        push_dig(18, 4'hB, 4'h0, 1'b1); push_dig(26, 4'h7, 4'h0, 1'b1);
        push_dig(34, 4'hE, 4'h4, 1'b1); push_dig(42, 4'hD, 4'h3, 1'b1);
        push_dig(50, 4'hB, 4'h2, 1'b1); push_dig(58, 4'h7, 4'h1, 1'b1);
        aq.push_back(32);
        load_at(1, 16'h1234, 4'h0);

        // 0xABCD loaded during digit 2 must wait for the frame edge.
        push_dig(66, 4'hE, 4'hD, 1'b1); push_dig(74, 4'hD, 4'hC, 1'b1);
        push_dig(82, 4'hB, 4'hB, 1'b1); push_dig(90, 4'h7, 4'hA, 1'b1);
        aq.push_back(64);
        load_at(49, 16'hABCD, 4'h0);

        // Two loads in one frame: last one wins, one ack.
        push_dig(98, 4'hE, 4'h2, 1'b1);  push_dig(106, 4'hD, 4'h2, 1'b1);
        push_dig(114, 4'hB, 4'h2, 1'b1); push_dig(122, 4'h7, 4'h2, 1'b1);
        aq.push_back(96);
        load_at(67, 16'h1111, 4'h0);
        load_at(70, 16'h2222, 4'h0);

        // Load on the wrap edge supersedes the pending 0x7777.
        push_dig(130, 4'hE, 4'h5, 1'b1); push_dig(138, 4'hD, 4'h5, 1'b0);
        push_dig(146, 4'hB, 4'h5, 1'b1); push_dig(154, 4'h7, 4'h5, 1'b1);
        aq.push_back(128);
        load_at(100, 16'h7777, 4'hF);
        load_at(128, 16'h5555, 4'b0010);

        // Leading-zero blanking: 0x0040, then 0x0000, then 0x0000 with dp on digit 2.
        push_dig(162, 4'hE, 4'h0, 1'b1); push_dig(170, 4'hD, 4'h4, 1'b1);
        aq.push_back(160);
        lz_en = 1'b1;
        load_at(129, 16'h0040, 4'h0);
        push_dig(194, 4'hE, 4'h0, 1'b1);
        aq.push_back(192);
        load_at(161, 16'h0000, 4'h0);
        push_dig(226, 4'hE, 4'h0, 1'b1); push_dig(242, 4'hB, 4'h0, 1'b0);
        aq.push_back(224);
        load_at(193, 16'h0000, 4'b0100);

        // Halt for five edges mid-way through digit 0 of frame 8; later digits shift by 5.
        push_dig(258, 4'hE, 4'h0, 1'b1);
        push_dig(265, 4'hE, 4'h0, 1'b1);
        push_dig(279, 4'hB, 4'h0, 1'b0);
        goto(259);
        en = 1'b0;
        goto(260);
        chk("halt_an_n_first", 32'(an_n), 32'hF);
        goto(264);
        chk("halt_an_n_held", 32'(an_n), 32'hF);
        chk("halt_dp_n", 32'(dp_n), 32'h1);
        en = 1'b1;

        // Reset mid-slot with a pending load: outputs dark at once, no ack afterwards.
        load_at(281, 16'h9999, 4'hF);
        goto(282);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_an_n", 32'(an_n), 32'hF);
        chk("midreset_hex_sel", 32'(hex_sel), 32'h0);
        chk("midreset_dp_n", 32'(dp_n), 32'h1);
        chk("midreset_load_ack", 32'(load_ack), 32'h0);
        #12;
        rst_n = 1'b1;
        push_dig(2, 4'hE, 4'h0, 1'b1);
        push_dig(34, 4'hE, 4'h0, 1'b1);
        goto(40);
        @(negedge clk);
        chk("digit_queue_drained", 32'(dq.size()), 32'h0);
        chk("ack_queue_drained", 32'(aq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
